// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants and FSM encodings for the MEM-stage memory handshake controller.
package mem_stage_ctrl_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned ADDR_ALIGN_BIT  = 0;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_dff.sv
// 16-bit register with enable and asynchronous active-high reset.
module dff_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one memory request at a time, stalls the pipeline
// while it is outstanding, and handles misalignment, timeout, error and halt.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemEn_in,
  input  logic              MemWr_in,
  input  logic              halt_in,
  input  logic              err_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mem_Stall,
  input  logic              mem_Done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_Rd,
  output logic              mem_Wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_createdump,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err_out,
  output logic              halt_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  // Only load completions carry meaningful read data, so stores leave the hold register alone.
  dff_16bit u_hold (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .d   (mem_rdata),
    .q   (hold_q)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    load_d         = load_q;
    hold_en        = 1'b0;
    mem_Rd         = 1'b0;
    mem_Wr         = 1'b0;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    mem_createdump = 1'b0;
    stall_out      = 1'b0;
    rdata_out      = hold_q;
    err_out        = err_in;
    halt_out       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (halt_in) begin
          mem_createdump = 1'b1;
          halt_out       = 1'b1;
          state_d        = ST_HALTED;
        end else if (MemEn_in && !err_in) begin
          if (addr_in[ADDR_ALIGN_BIT]) begin
            err_out = 1'b1;
          end else if (mem_Stall) begin
            stall_out = 1'b1;
          end else begin
            mem_Rd    = !MemWr_in;
            mem_Wr    = MemWr_in;
            mem_addr  = addr_in;
            mem_wdata = wdata_in;
            addr_d    = addr_in;
            wdata_d   = wdata_in;
            load_d    = !MemWr_in;
            if (mem_Done) begin
              rdata_out = mem_rdata;
              hold_en   = !MemWr_in;
            end else begin
              stall_out = 1'b1;
              state_d   = ST_WAIT;
              cnt_d     = '0;
            end
          end
        end
      end
      ST_WAIT: begin
        stall_out = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (mem_Done) begin
          stall_out = 1'b0;
          rdata_out = mem_rdata;
          hold_en   = load_q;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_out   = 1'b1;
          stall_out = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_HALTED: begin
        stall_out = 1'b1;
        halt_out  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset is asynchronous, so the combinational outputs are silenced with it too.
    if (rst) begin
      hold_en        = 1'b0;
      mem_Rd         = 1'b0;
      mem_Wr         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      mem_createdump = 1'b0;
      stall_out      = 1'b0;
      rdata_out      = '0;
      err_out        = 1'b0;
      halt_out       = 1'b0;
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL use one clock and one reset: clk (rising edge); rst asynchronous, active-high.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited for mem_Done before faulting.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 MemEn_in  in  1  stage instruction accesses memory (from EX/MEM register).
REQ-006 MemWr_in  in  1  access is a store; else load.
REQ-007 halt_in  in  1  stage instruction is HALT.
REQ-008 err_in  in  1  upstream error.
REQ-009 addr_in  in  16  ALU result used as byte address.
REQ-010 wdata_in  in  16  store data.
REQ-011 mem_Stall  in  1  memory busy, cannot accept a request.
REQ-012 mem_Done  in  1  memory completed the outstanding request; mem_rdata valid if load.
REQ-013 mem_rdata  in  16  memory read data.
REQ-014 mem_Rd, mem_Wr  out  1 each  one-cycle request strobes.
REQ-015 mem_addr, mem_wdata  out  16 each  request address/data.
REQ-016 mem_createdump  out  1  one-cycle dump strobe on halt.
REQ-017 stall_out  out  1  freezes PC, IF/ID, ID/EX, EX/MEM (drives their en low).
REQ-018 rdata_out  out  16  load data toward MEM/WB.
REQ-019 err_out, halt_out  out  1 each  error/halt toward MEM/WB.

Function
REQ-020 SHALL implement states IDLE, WAIT, HALTED.
REQ-021 IDLE, MemEn_in=1, addr_in[0]=0, err_in=0, mem_Stall=0: SHALL pulse mem_Rd (load) or mem_Wr (store) this cycle with mem_addr=addr_in, mem_wdata=wdata_in, and latch addr, wdata, direction.
REQ-022 If mem_Done=1 in the issue cycle: stall_out=0, rdata_out=mem_rdata, remain IDLE (zero-wait access).
REQ-023 Else: stall_out=1, next state WAIT, wait counter cleared.
REQ-024 IDLE with mem_Stall=1 and a pending access: no strobe, stall_out=1, remain IDLE, retry next cycle.
REQ-025 WAIT: stall_out=1, no strobes, mem_addr/mem_wdata hold latched values, counter increments by 1 per cycle.
REQ-026 WAIT with mem_Done=1: stall_out=0 that cycle, rdata_out=mem_rdata, capture mem_rdata into hold register, next state IDLE.
REQ-027 WAIT, counter reaching TIMEOUT without mem_Done: err_out=1 for one cycle, stall_out=0, next state IDLE.
REQ-028 Outside REQ-022/026, rdata_out SHALL present the hold register.
REQ-029 MemEn_in=1 with addr_in[0]=1: no strobe, err_out=1, stall_out=0.
REQ-030 err_in=1: no strobe, err_out=1 same cycle (combinational pass-through).
REQ-031 IDLE, halt_in=1 (MemEn_in ignored): mem_createdump=1 for exactly one cycle, halt_out=1, next state HALTED.
REQ-032 HALTED: stall_out=1, halt_out=1, no strobes, held until reset.
REQ-033 mem_Done while IDLE with no outstanding request SHALL be ignored.
REQ-034 At most one request outstanding; mem_Rd and mem_Wr never both 1.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, counter 0, hold register 0, all outputs 0, including mid-WAIT (outstanding request abandoned).

Structure
REQ-036 State encodings (2-bit) and TIMEOUT default SHALL live in the shared package with the pipeline control constants.
REQ-037 Hold register SHALL be an instance of the existing dff_16bit (en = capture condition); FSM and counter are local.

Verification
REQ-038 Load 0x0040, mem_Done in issue cycle, mem_rdata=0xBEEF -> mem_Rd one cycle, stall_out never 1, rdata_out=0xBEEF.
REQ-039 Store 0x0010 data 0x1234, mem_Done 3 cycles later -> mem_Wr one cycle, mem_addr/mem_wdata held, stall_out=1 for exactly 3 cycles.
REQ-040 Load addr 0x0003 -> no strobe, err_out=1, stall_out=0.
REQ-041 mem_Stall=1 for 2 cycles, then load 0x0020 -> strobe on 3rd cycle, stall_out=1 for first 2 cycles.
REQ-042 Load, mem_Done never, TIMEOUT=4 -> err_out pulse on 4th WAIT cycle, return IDLE.
REQ-043 rst mid-WAIT -> all outputs 0 immediately; halt_in after reset -> one mem_createdump pulse, stall_out stuck 1.
